// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0;
    localparam logic [31:0] PC_STEP   = 32'd4;

    // One buffered instruction together with the address of its successor.
    typedef struct packed {
        logic [31:0] seq_pc;
        logic [31:0] instr;
    } entry_t;

    localparam int unsigned ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/fetch_queue_if.sv
// Memory-side and pipeline-side handshake bundle of the fetch queue.
interface fetch_queue_if #(
    parameter int unsigned DEPTH = 4
) ();

    logic                     mem_req_o;
    logic [31:0]              mem_addr_o;
    logic                     mem_gnt_i;
    logic                     mem_rvalid_i;
    logic [31:0]              mem_rdata_i;
    logic                     redirect_i;
    logic [31:0]              redirect_pc_i;
    logic                     stall_i;
    logic                     instr_valid_o;
    logic [31:0]              instr_o;
    logic [31:0]              seq_pc_o;
    logic [$clog2(DEPTH):0]   count_o;

    modport master (
        output mem_req_o, mem_addr_o, instr_valid_o, instr_o, seq_pc_o, count_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i, redirect_i, redirect_pc_i, stall_i
    );

    modport slave (
        input  mem_req_o, mem_addr_o, instr_valid_o, instr_o, seq_pc_o, count_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i, redirect_i, redirect_pc_i, stall_i
    );

endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO with flush; head is read straight from storage.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clear_i,
    input  logic                   push_i,
    input  entry_t                 push_data_i,
    input  logic                   pop_i,
    output logic                   head_valid_o,
    output entry_t                 head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

    entry_t          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW:0]     count_q, count_d;
    logic            do_push, do_pop;

    // Pointer and occupancy update; flush wins over push/pop.
    always_comb begin
        do_pop   = pop_i & ~clear_i & (count_q != '0);
        // Push into a full FIFO is only legal when the head leaves the same cycle.
        do_push  = push_i & ~clear_i & ((count_q != FULL) | do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            count_d = count_q + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, no reset needed: reads are gated by occupancy.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    // Head presentation; empty FIFO shows a NOP with zero PC.
    always_comb begin
        head_valid_o = (count_q != '0);
        head_o       = '0;
        head_o.instr = NOP_INSTR;
        if (head_valid_o) head_o = mem_q[rd_ptr_q];
    end

    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: issues sequential fetches, buffers responses,
// flushes and restarts on a taken branch.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk_i,
    input  logic          rst_i,
    fetch_queue_if.master bus
);

    localparam int unsigned CW     = $clog2(DEPTH) + 1;
    localparam logic [CW:0] CREDIT = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   push_pc_q, push_pc_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [CW-1:0] count;
    logic          handshake, push, pop, head_valid;
    entry_t        push_entry, head;

    // Request while buffer slots plus in-flight fetches leave room; held low in reset.
    always_comb begin
        bus.mem_req_o = rst_i & ~bus.redirect_i &
                        (({1'b0, count} + {1'b0, outst_q}) < CREDIT);
        handshake     = bus.mem_req_o & bus.mem_gnt_i;
    end

    // PC, outstanding and discard bookkeeping; a redirect overrides everything.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        push_pc_d  = push_pc_q;
        discard_d  = discard_q;
        push       = 1'b0;
        outst_d    = outst_q + CW'(handshake) - CW'(bus.mem_rvalid_i);
        if (handshake) fetch_pc_d = fetch_pc_q + PC_STEP;
        if (bus.mem_rvalid_i) begin
            if (discard_q != '0) begin
                discard_d = discard_q - CW'(1);
            end else begin
                push      = 1'b1;
                push_pc_d = push_pc_q + PC_STEP;
            end
        end
        if (bus.redirect_i) begin
            fetch_pc_d = bus.redirect_pc_i;
            push_pc_d  = bus.redirect_pc_i;
            // Everything still in flight after this cycle belongs to the old path.
            discard_d  = outst_d;
            push       = 1'b0;
        end
    end

    // Fetch-side state registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fetch_pc_q <= RESET_PC;
            push_pc_q  <= RESET_PC;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            push_pc_q  <= push_pc_d;
            outst_q    <= outst_d;
            discard_q  <= discard_d;
        end
    end

    assign push_entry = '{seq_pc: push_pc_q + PC_STEP, instr: bus.mem_rdata_i};
    assign pop        = head_valid & ~bus.stall_i & ~bus.redirect_i;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (bus.redirect_i),
        .push_i       (push),
        .push_data_i  (push_entry),
        .pop_i        (pop),
        .head_valid_o (head_valid),
        .head_o       (head),
        .count_o      (count)
    );

    assign bus.mem_addr_o    = fetch_pc_q;
    assign bus.instr_valid_o = head_valid;
    assign bus.instr_o       = head.instr;
    assign bus.seq_pc_o      = head.seq_pc;
    assign bus.count_o       = count;

endmodule
